operand_issue: RTL
==================

// Module: operand_issue
// PURPOSE
//  Decode/operand-fetch stage that sits directly upstream of the integer register file.
//  - Takes fetched RV32I instructions through a valid/ready handshake.
//  - Drives the register-file read addresses and captures the operands.
//  - Tracks pending destination writes in a scoreboard and stalls on RAW/WAW hazards.
//  - Presents one registered issue packet to execute.
//  - The writeback bus that writes the register file also retires scoreboard entries here.
// PARAMETERS
//  XLEN       32   datapath / instruction width
//  NUM_REGS   32   architectural registers; x0 is hard-wired zero
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     asynchronous, active-low reset
//  flush         in   1     discard held packet and scoreboard state
//  in_valid      in   1     fetch offers an instruction
//  in_ready      out  1     stage accepts this cycle
//  in_inst       in   XLEN  instruction word
//  in_pc         in   XLEN  instruction PC
//  rs1_addr      out  5     register-file read address 1 (combinational from in_inst[19:15])
//  rs2_addr      out  5     register-file read address 2 (combinational from in_inst[24:20])
//  rs1_data      in   XLEN  register-file read data 1 (combinational return)
//  rs2_data      in   XLEN  register-file read data 2
//  wb_en         in   1     writeback valid (same bus drives register-file rd_en)
//  wb_addr       in   5     writeback register
//  wb_data       in   XLEN  writeback value
//  out_valid     out  1     issue packet valid
//  out_ready     in   1     execute accepts packet
//  out_inst      out  XLEN  issued instruction
//  out_pc        out  XLEN  issued PC
//  out_rs1_val   out  XLEN  operand 1 (0 if rs1 unused or x0)
//  out_rs2_val   out  XLEN  operand 2 (0 if rs2 unused or x0)
//  out_rd_addr   out  5     destination register
//  out_rd_wen    out  1     destination is written (rd != 0)
// BEHAVIOUR
//  Reset:
//  - All out_* = 0 and scoreboard = 0.
//  - in_ready follows its equation (1 after reset when in_valid=0 or no hazard).
//  Decode by opcode [6:0]:
//  - rs1 used by: OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
//  - rs2 used by: OP, STORE, BRANCH.
//  - rd written by: OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR.
//  - Any other opcode: no sources, no rd; it still issues.
//  - Unused fields never raise a hazard; x0 is never pending.
//  Hazard condition:
//  - hazard = (use1 & busy[rs1]) | (use2 & busy[rs2]) | (wen & busy[rd]).
//  - busy = pending, or pending & ~wb_clear with BYPASS_EN.
//  Handshake and issue:
//  - in_ready = ~hazard & (~out_valid | out_ready).
//  - issue = in_valid & in_ready.
//  - Latency: one cycle from issue to out_valid.
//  - Packet is held stable while out_valid & ~out_ready.
//  - out_valid falls on out_ready & ~issue.
//  Scoreboard update (per edge):
//  - Clear bit wb_addr when wb_en & wb_addr != 0.
//  - Set bit rd on issue & wen.
//  - Set wins on simultaneous set/clear of the same bit.
//  Flush:
//  - Synchronous; out_valid <= 0, scoreboard <= 0, in_ready forced 0 that cycle.
//  - Overrides a same-cycle issue.
//  - Downstream guarantees no uncommitted older writer survives a flush.
//  - A stray wb_en after flush clears an already-clear bit (harmless).
//  Reset mid-packet: out_valid drops asynchronously; packet is lost.
// CONFIGURATION
//  OPERAND_BYPASS_EN defined:
//  - Operands take wb_data when wb_en & wb_addr == rs (rs != 0).
//  - A register retiring this cycle is not busy, so a dependent issues in the writeback cycle.
//  Undefined:
//  - Operands come from the register file only.
//  - The dependent issues the cycle after writeback, when register-file data is visible.
// STRUCTURE
//  riscv_pkg holds:
//  - Opcode localparams.
//  - The decoded-use struct {use1, use2, wen, rs1, rs2, rd}.
//  - The issue-packet struct.
//  Sub-module reg_scoreboard:
//  - 32-bit pending vector with set/clear/flush ports.
//  - Combinational busy lookup for three addresses.
// TESTING
//  - Reset then ADDI x1,x0,5 (0x00500093) -> out_valid next cycle, out_rd_addr=1, out_rd_wen=1, pending[1]=1.
//  - ADD x3,x1,x2 behind pending x1, wb_en x1=0xA -> in_ready=0 until retire; bypass: issues in wb cycle with
//    out_rs1_val=0xA; no bypass: issues one cycle later, operand from register file.
//  - out_ready=0 for 3 cycles with valid packet -> out_* stable, in_ready=0, no scoreboard change.
//  - Issue ADDI x5 in same cycle as wb_en x5 of older writer -> pending[5] stays 1 (set wins).
//  - LUI x0 / STORE with rs2=x0 -> no hazard ever, out_rd_wen=0, pending unchanged.
//  - Flush with out_valid=1 and pending={x1,x4} -> next cycle out_valid=0, pending=0, stalled dependent issues.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode types for the operand-issue stage: opcodes, decoded-use
// struct, issue packet, and the source/destination decode helper.
package riscv_pkg;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int RW       = $clog2(NUM_REGS);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic          use1;
    logic          use2;
    logic          wen;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
  } dec_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [RW-1:0]   rd_addr;
    logic            rd_wen;
  } issue_pkt_t;

  // x0 is folded in here so nothing downstream can ever see a hazard on it.
  function automatic dec_t decode(input logic [6:0] opc, input logic [RW-1:0] rs1,
                                  input logic [RW-1:0] rs2, input logic [RW-1:0] rd);
    dec_t d;
    logic u1, u2, w;
    u1 = 1'b0;
    u2 = 1'b0;
    w  = 1'b0;
    case (opc)
      OPC_OP:                         begin u1 = 1'b1; u2 = 1'b1; w = 1'b1; end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin u1 = 1'b1; w = 1'b1; end
      OPC_STORE, OPC_BRANCH:          begin u1 = 1'b1; u2 = 1'b1; end
      OPC_LUI, OPC_AUIPC, OPC_JAL:    w = 1'b1;
      default:                        ;
    endcase
    d.rs1  = rs1;
    d.rs2  = rs2;
    d.rd   = rd;
    d.use1 = u1 & (rs1 != '0);
    d.use2 = u2 & (rs2 != '0);
    d.wen  = w  & (rd  != '0);
    return d;
  endfunction
endpackage

// File: rtl/operand_issue_if.sv
// Fetch, register-file, writeback and execute buses of the operand-issue stage.
interface operand_issue_if;
  import riscv_pkg::*;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_inst;
  logic [XLEN-1:0] in_pc;
  logic [RW-1:0]   rs1_addr;
  logic [RW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wb_en;
  logic [RW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic [RW-1:0]   out_rd_addr;
  logic            out_rd_wen;

  modport slave (
    input  flush, in_valid, in_inst, in_pc, rs1_data, rs2_data,
           wb_en, wb_addr, wb_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_inst, out_pc,
           out_rs1_val, out_rs2_val, out_rd_addr, out_rd_wen
  );

  modport master (
    output flush, in_valid, in_inst, in_pc, rs1_data, rs2_data,
           wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_inst, out_pc,
           out_rs1_val, out_rs2_val, out_rd_addr, out_rd_wen
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard with three busy lookups (rs1, rs2, rd).
// OPERAND_BYPASS_EN: a register retiring this cycle is reported as not busy.
module reg_scoreboard
  import riscv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     set_en,
  input  logic [RW-1:0]            set_addr,
  input  logic                     clr_en,
  input  logic [RW-1:0]            clr_addr,
  input  logic [2:0][RW-1:0]       q_addr,
  output logic [2:0]               q_busy,
  output logic [NUM_REGS-1:0]      pending
);
  logic [NUM_REGS-1:0] set_vec, clr_vec, busy_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en && set_addr != '0) set_vec[set_addr] = 1'b1;
    if (clr_en && clr_addr != '0) clr_vec[clr_addr] = 1'b1;
  end

  // Set is applied after clear so a new writer wins over an older retiring one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       pending <= '0;
    else if (flush) pending <= '0;
    else            pending <= (pending & ~clr_vec) | set_vec;
  end

`ifdef OPERAND_BYPASS_EN
  assign busy_vec = pending & ~clr_vec;
`else
  assign busy_vec = pending;
`endif

  for (genvar g = 0; g < 3; g++) begin : g_q
    assign q_busy[g] = busy_vec[q_addr[g]];
  end
endmodule

// File: rtl/operand_issue.sv
// RV32I decode/operand-fetch stage: RAW/WAW scoreboard stall, one registered issue slot.
// OPERAND_BYPASS_EN: forward same-cycle writeback data into operands.
module operand_issue
  import riscv_pkg::*;
(
  input logic            clk,
  input logic            rst,
  operand_issue_if.slave io
);
  dec_t            dec;
  logic [2:0]      q_busy;
  logic            hazard, issue, out_vld;
  logic [XLEN-1:0] op1, op2;
  issue_pkt_t      pkt;
  logic [NUM_REGS-1:0] pending;

  assign dec         = decode(io.in_inst[6:0], io.in_inst[19:15], io.in_inst[24:20], io.in_inst[11:7]);
  assign io.rs1_addr = io.in_inst[19:15];
  assign io.rs2_addr = io.in_inst[24:20];

  reg_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .flush    (io.flush),
    .set_en   (issue & dec.wen),
    .set_addr (dec.rd),
    .clr_en   (io.wb_en),
    .clr_addr (io.wb_addr),
    .q_addr   ({dec.rd, dec.rs2, dec.rs1}),
    .q_busy   (q_busy),
    .pending  (pending)
  );

  assign hazard      = io.in_valid & ((dec.use1 & q_busy[0]) | (dec.use2 & q_busy[1]) |
                                      (dec.wen  & q_busy[2]));
  assign io.in_ready = ~io.flush & ~hazard & (~out_vld | io.out_ready);
  assign issue       = io.in_valid & io.in_ready;

`ifdef OPERAND_BYPASS_EN
  // use1/use2 already exclude x0, so an address match implies a real register.
  assign op1 = !dec.use1 ? '0 : (io.wb_en && io.wb_addr == dec.rs1) ? io.wb_data : io.rs1_data;
  assign op2 = !dec.use2 ? '0 : (io.wb_en && io.wb_addr == dec.rs2) ? io.wb_data : io.rs2_data;
`else
  logic unused_wb;
  assign unused_wb = ^io.wb_data;
  assign op1 = dec.use1 ? io.rs1_data : '0;
  assign op2 = dec.use2 ? io.rs2_data : '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld <= 1'b0;
      pkt     <= '0;
    end else if (io.flush) begin
      out_vld <= 1'b0;
    end else if (issue) begin
      out_vld     <= 1'b1;
      pkt.inst    <= io.in_inst;
      pkt.pc      <= io.in_pc;
      pkt.rs1_val <= op1;
      pkt.rs2_val <= op2;
      pkt.rd_addr <= dec.rd;
      pkt.rd_wen  <= dec.wen;
    end else if (io.out_ready) begin
      out_vld <= 1'b0;
    end
  end

  logic unused_pend;
  assign unused_pend = ^pending;

  assign io.out_valid   = out_vld;
  assign io.out_inst    = pkt.inst;
  assign io.out_pc      = pkt.pc;
  assign io.out_rs1_val = pkt.rs1_val;
  assign io.out_rs2_val = pkt.rs2_val;
  assign io.out_rd_addr = pkt.rd_addr;
  assign io.out_rd_wen  = pkt.rd_wen;
endmodule
